rr_mux_demux: RTL and testbench
===============================

Name: rr_mux_demux

Overview:
- Parametrised, registered successor to the team's fixed 4:1 mux / 1:4 demux.
- Mux path: round-robin arbitration over N valid/ready input channels into one registered output stream; reports which channel supplied each word.
- Demux path: routes one addressed input stream into N independently back-pressured registered outputs.
- Sits between per-channel producers/consumers and a single shared datapath.

Parameters:
- N, 4: channel count; legal range 2..16, power of two not required.
- W, 8: data width in bits, >=1.
- SW, derived = max(1, clog2(N)): select width. Localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_data  in  N*W  mux inputs; channel k at [k*W +: W]
- in_valid  in  N  per-channel request
- in_ready  out  N  per-channel accept (one-hot or zero)
- y_data  out  W  registered mux output
- y_valid  out  1  y_data valid
- y_ready  in  1  downstream accept
- y_sel  out  SW  source channel of y_data
- d_data  in  W  demux input word
- d_sel  in  SW  destination channel
- d_valid  in  1  demux input valid
- d_ready  out  1  demux input accept
- out_data  out  N*W  registered demux outputs; channel k at [k*W +: W]
- out_valid  out  N  per-channel valid
- out_ready  in  N  per-channel accept
- drop_err  out  1  sticky: word addressed to channel >= N was discarded

Behaviour:
- Reset: while rst is high at a clk edge, all of these clear to 0: y_valid, y_data, y_sel, out_valid, out_data, drop_err, and the priority pointer ptr. rst mid-transfer discards in-flight words with no completion. During rst: in_ready = 0 and d_ready = 0.
- Handshake: a transfer occurs on a cycle where valid & ready are both 1 at the clk edge. A producer holds data/valid stable until accepted. The block holds each output register stable while its valid=1 and ready=0.
- Mux load condition: load = ~y_valid | y_ready.
- Arbiter grant: the first k with in_valid[k]=1, scanning ptr, ptr+1, ..., wrapping modulo N. Grant is combinational.
- in_ready: in_ready[k] = load & (grant==k) & any(in_valid). At most one bit is set.
- On grant transfer: y_data <= in_data[k], y_sel <= k, y_valid <= 1, ptr <= (k+1) mod N. Wrap is explicit so non-power-of-two N works.
- Load with no request: y_valid <= 0; ptr unchanged.
- Mux latency: 1 cycle from accept to y_valid. Full throughput of one word per cycle when y_ready is held high.
- Fairness: a continuously requesting channel waits at most N-1 grants.
- Demux acceptance: d_ready = ~out_valid[d_sel] | out_ready[d_sel] when d_sel < N. Acceptance depends only on the addressed channel; no head-of-line blocking from other channels.
- On demux transfer with d_sel < N: out_data[d_sel] <= d_data, out_valid[d_sel] <= 1.
- Per channel k, when out_ready[k] & out_valid[k] and k is not being loaded this cycle: out_valid[k] <= 0.
- Simultaneous drain and load of the same channel: valid stays 1 and data is replaced (pass-through, 1-cycle latency).
- d_sel >= N (only possible when N is not a power of two): d_ready = 1, word discarded, drop_err <= 1. drop_err clears only on rst.
- Mux and demux paths are fully independent and may transfer in the same cycle.

Decomposition:
- Package rr_pkg: clog2 function, defaults DEF_N=4 and DEF_W=8.
- One sub-module, rr_arbiter (N): inputs req[N], ptr, en; outputs grant index, grant_vld, next_ptr. Purely combinational except the ptr register, which rr_arbiter owns with the same clk/rst.
- The demux is a generate loop of N identical output registers inside the top; no separate module.

Test Plan:
- Reset: hold rst 2 cycles with all valids=1 -> every output 0, in_ready=0, d_ready=0; first grant after release is channel 0.
- Round-robin: N=4, in_valid=4'b1111, in_data k = 8'hA0+k, y_ready=1 -> y_sel sequence 0,1,2,3,0; y_data A0,A1,A2,A3,A0; one word per cycle.
- Backpressure: y_ready=0 for 3 cycles with y_valid=1 -> y_data and y_sel frozen, in_ready=0; release -> next grant follows ptr with no word lost or duplicated.
- Sparse request: in_valid=4'b1010 with ptr=0 -> grants 1,3,1,3; then only channel 2 requests -> granted on the next load.
- Demux blocking: out_ready=0 on channel 2, two words to d_sel=2 -> first accepted, d_ready=0 for the second; meanwhile a word to d_sel=1 is accepted; raise out_ready[2] -> second word accepted on the same cycle.
- N=3, d_sel=3 with d_valid=1 -> d_ready=1, out_valid unchanged, drop_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin mux / addressed demux block.
// Holds default sizing and the select-width helper.
package rr_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << r) < v) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant logic over N requesters.
// Owns the rotating priority pointer; grant itself is combinational.
module rr_arbiter
    import rr_pkg::*;
#(
    parameter  int N  = DEF_N,
    localparam int SW = sel_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [SW-1:0] grant,
    output logic          grant_vld
);

    logic [SW-1:0] r_ptr;
    logic [SW-1:0] w_next_ptr;

    // Scan ptr, ptr+1, ... with explicit modulo-N wrap for non-pow2 N.
    always_comb begin
        int p;
        int idx;
        grant     = '0;
        grant_vld = 1'b0;
        p         = int'(r_ptr);
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = p + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            for (int k = 0; k < N; k++) begin
                if (!grant_vld && (k == idx) && req[k]) begin
                    grant_vld = 1'b1;
                    grant     = SW'(k);
                end
            end
        end
    end

    assign w_next_ptr = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en && grant_vld) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/rr_mux_demux.sv
// N:1 round-robin registered mux plus 1:N addressed registered demux.
// The two paths share only clock and reset.
module rr_mux_demux
    import rr_pkg::*;
#(
    parameter  int N  = DEF_N,
    parameter  int W  = DEF_W,
    localparam int SW = sel_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   y_data,
    output logic           y_valid,
    input  logic           y_ready,
    output logic [SW-1:0]  y_sel,
    input  logic [W-1:0]   d_data,
    input  logic [SW-1:0]  d_sel,
    input  logic           d_valid,
    output logic           d_ready,
    output logic [N*W-1:0] out_data,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
    output logic           drop_err
);

    logic [SW-1:0] w_grant;
    logic          w_grant_vld;
    logic          w_load;
    logic          w_mux_xfer;
    logic [W-1:0]  w_gdata;

    logic          r_y_valid;
    logic [W-1:0]  r_y_data;
    logic [SW-1:0] r_y_sel;

    assign w_load     = ~r_y_valid | y_ready;
    assign w_mux_xfer = w_load & w_grant_vld & ~rst;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .en        (w_mux_xfer),
        .grant     (w_grant),
        .grant_vld (w_grant_vld)
    );

    always_comb begin
        in_ready = '0;
        w_gdata  = '0;
        for (int k = 0; k < N; k++) begin
            if (w_grant == SW'(k)) begin
                in_ready[k] = w_mux_xfer;
                w_gdata     = in_data[k*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_y_sel   <= '0;
        end else if (w_load) begin
            r_y_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_y_data <= w_gdata;
                r_y_sel  <= w_grant;
            end
        end
    end

    assign y_valid = r_y_valid;
    assign y_data  = r_y_data;
    assign y_sel   = r_y_sel;

    logic          w_oob;
    logic          w_ch_rdy;
    logic [N-1:0]  w_hit;
    logic [N-1:0]  w_dload;
    logic          r_drop_err;

    // Out-of-range selects only exist when N is not a power of two.
    assign w_oob = (32'(d_sel) >= 32'(N));

    always_comb begin
        w_hit    = '0;
        w_ch_rdy = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_hit[k] = ~w_oob & (d_sel == SW'(k));
            w_ch_rdy = w_ch_rdy | (w_hit[k] & (~out_valid[k] | out_ready[k]));
        end
    end

    assign d_ready = ~rst & (w_oob | w_ch_rdy);
    assign w_dload = {N{d_valid & d_ready}} & w_hit;

    for (genvar k = 0; k < N; k++) begin : g_ch
        logic         r_valid;
        logic [W-1:0] r_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_dload[k]) begin
                r_valid <= 1'b1;
                r_data  <= d_data;
            end else if (out_ready[k]) begin
                r_valid <= 1'b0;
            end
        end

        assign out_valid[k]        = r_valid;
        assign out_data[k*W +: W]  = r_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_err <= 1'b0;
        end else if (d_valid && d_ready && w_oob) begin
            r_drop_err <= 1'b1;
        end
    end

    assign drop_err = r_drop_err;

endmodule

// File: tb/tb_rr_mux_demux.sv
// Directed bench for rr_mux_demux: N=4 vector table plus an N=3 instance
// for modulo wrap and out-of-range demux selects.
module tb_rr_mux_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // N=4 instance
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [7:0]  y_data;
    logic        y_valid, y_ready;
    logic [1:0]  y_sel;
    logic [7:0]  d_data;
    logic [1:0]  d_sel;
    logic        d_valid, d_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid, out_ready;
    logic        drop_err;

    rr_mux_demux #(.N(4), .W(8)) u4 (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .y_sel(y_sel),
        .d_data(d_data), .d_sel(d_sel), .d_valid(d_valid), .d_ready(d_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_err(drop_err)
    );

    // N=3 instance
    logic        rst3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [7:0]  y_data3;
    logic        y_valid3, y_ready3;
    logic [1:0]  y_sel3;
    logic [7:0]  d_data3;
    logic [1:0]  d_sel3;
    logic        d_valid3, d_ready3;
    logic [23:0] out_data3;
    logic [2:0]  out_valid3, out_ready3;
    logic        drop_err3;

    rr_mux_demux #(.N(3), .W(8)) u3 (
        .clk(clk), .rst(rst3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .y_data(y_data3), .y_valid(y_valid3), .y_ready(y_ready3), .y_sel(y_sel3),
        .d_data(d_data3), .d_sel(d_sel3), .d_valid(d_valid3), .d_ready(d_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
        .drop_err(drop_err3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] vmask(input logic [3:0] v);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            if (v[k]) m[k*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

    typedef struct {
        logic        rst;
        logic [3:0]  iv;
        logic        yr;
        logic        dv;
        logic [1:0]  ds;
        logic [7:0]  dd;
        logic [3:0]  ordy;
        logic [3:0]  e_ir;
        logic        e_yv;
        logic [1:0]  e_ys;
        logic [7:0]  e_yd;
        logic        e_dr;
        logic [3:0]  e_ov;
        logic [31:0] e_od;
    } vec_t;

    localparam int NV = 24;
    vec_t v [NV];

    initial begin
        // rst iv    yr dv ds dd     ordy | ir   yv ys dat    dr ov    od
        v[0]  = '{0, 4'hF, 1, 0, 0, 8'h00, 4'hF, 4'h1, 0, 0, 8'h00, 1, 4'h0, 32'h0};
        v[1]  = '{0, 4'hF, 1, 0, 0, 8'h00, 4'hF, 4'h2, 1, 0, 8'hA0, 1, 4'h0, 32'h0};
        v[2]  = '{0, 4'hF, 1, 0, 0, 8'h00, 4'hF, 4'h4, 1, 1, 8'hA1, 1, 4'h0, 32'h0};
        v[3]  = '{0, 4'hF, 1, 0, 0, 8'h00, 4'hF, 4'h8, 1, 2, 8'hA2, 1, 4'h0, 32'h0};
        v[4]  = '{0, 4'hF, 1, 0, 0, 8'h00, 4'hF, 4'h1, 1, 3, 8'hA3, 1, 4'h0, 32'h0};
        v[5]  = '{0, 4'hF, 0, 0, 0, 8'h00, 4'hF, 4'h0, 1, 0, 8'hA0, 1, 4'h0, 32'h0};
        v[6]  = '{0, 4'hF, 0, 0, 0, 8'h00, 4'hF, 4'h0, 1, 0, 8'hA0, 1, 4'h0, 32'h0};
        v[7]  = '{0, 4'hF, 0, 0, 0, 8'h00, 4'hF, 4'h0, 1, 0, 8'hA0, 1, 4'h0, 32'h0};
        v[8]  = '{0, 4'hF, 1, 0, 0, 8'h00, 4'hF, 4'h2, 1, 0, 8'hA0, 1, 4'h0, 32'h0};
        v[9]  = '{1, 4'hA, 1, 0, 0, 8'h00, 4'hF, 4'h0, 1, 1, 8'hA1, 0, 4'h0, 32'h0};
        v[10] = '{0, 4'hA, 1, 0, 0, 8'h00, 4'hF, 4'h2, 0, 0, 8'h00, 1, 4'h0, 32'h0};
        v[11] = '{0, 4'hA, 1, 0, 0, 8'h00, 4'hF, 4'h8, 1, 1, 8'hA1, 1, 4'h0, 32'h0};
        v[12] = '{0, 4'hA, 1, 0, 0, 8'h00, 4'hF, 4'h2, 1, 3, 8'hA3, 1, 4'h0, 32'h0};
        v[13] = '{0, 4'hA, 1, 0, 0, 8'h00, 4'hF, 4'h8, 1, 1, 8'hA1, 1, 4'h0, 32'h0};
        v[14] = '{0, 4'h4, 1, 0, 0, 8'h00, 4'hF, 4'h4, 1, 3, 8'hA3, 1, 4'h0, 32'h0};
        v[15] = '{0, 4'h0, 1, 0, 0, 8'h00, 4'hF, 4'h0, 1, 2, 8'hA2, 1, 4'h0, 32'h0};
        v[16] = '{0, 4'h0, 1, 0, 0, 8'h00, 4'hF, 4'h0, 0, 0, 8'h00, 1, 4'h0, 32'h0};
        v[17] = '{0, 4'h0, 1, 1, 2, 8'h11, 4'hB, 4'h0, 0, 0, 8'h00, 1, 4'h0, 32'h0};
        v[18] = '{0, 4'h0, 1, 1, 2, 8'h22, 4'hB, 4'h0, 0, 0, 8'h00, 0, 4'h4, 32'h00110000};
        v[19] = '{0, 4'h0, 1, 1, 1, 8'h33, 4'h9, 4'h0, 0, 0, 8'h00, 1, 4'h4, 32'h00110000};
        v[20] = '{0, 4'h0, 1, 1, 2, 8'h22, 4'h9, 4'h0, 0, 0, 8'h00, 0, 4'h6, 32'h00113300};
        v[21] = '{0, 4'h1, 1, 1, 2, 8'h22, 4'hD, 4'h1, 0, 0, 8'h00, 1, 4'h6, 32'h00113300};
        v[22] = '{0, 4'h0, 1, 0, 2, 8'h00, 4'hF, 4'h0, 1, 0, 8'hA0, 1, 4'h6, 32'h00223300};
        v[23] = '{0, 4'h0, 1, 0, 2, 8'h00, 4'h0, 4'h0, 0, 0, 8'h00, 1, 4'h0, 32'h0};
    end

    initial begin
        in_data   = 32'hA3A2A1A0;
        in_data3  = 24'hA2A1A0;
        rst = 1'b1;       rst3 = 1'b1;
        in_valid = 4'hF;  in_valid3 = 3'h7;
        y_ready = 1'b1;   y_ready3 = 1'b1;
        d_valid = 1'b1;   d_valid3 = 1'b1;
        d_sel = 2'd0;     d_sel3 = 2'd0;
        d_data = 8'h5A;   d_data3 = 8'h5A;
        out_ready = 4'h0; out_ready3 = 3'h0;

        // Reset with every valid asserted
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst y_valid", 32'(y_valid), 32'h0);
        chk("rst y_data", 32'(y_data), 32'h0);
        chk("rst y_sel", 32'(y_sel), 32'h0);
        chk("rst in_ready", 32'(in_ready), 32'h0);
        chk("rst d_ready", 32'(d_ready), 32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst out_data", out_data, 32'h0);
        chk("rst drop_err", 32'(drop_err), 32'h0);
        chk("rst3 in_ready", 32'(in_ready3), 32'h0);
        chk("rst3 d_ready", 32'(d_ready3), 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst       = v[i].rst;
            in_valid  = v[i].iv;
            y_ready   = v[i].yr;
            d_valid   = v[i].dv;
            d_sel     = v[i].ds;
            d_data    = v[i].dd;
            out_ready = v[i].ordy;
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(v[i].e_ir));
            chk($sformatf("v%0d y_valid", i), 32'(y_valid), 32'(v[i].e_yv));
            if (v[i].e_yv) begin
                chk($sformatf("v%0d y_sel", i), 32'(y_sel), 32'(v[i].e_ys));
                chk($sformatf("v%0d y_data", i), 32'(y_data), 32'(v[i].e_yd));
            end
            chk($sformatf("v%0d d_ready", i), 32'(d_ready), 32'(v[i].e_dr));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(v[i].e_ov));
            chk($sformatf("v%0d out_data", i),
                out_data & vmask(v[i].e_ov), v[i].e_od);
        end
        chk("n4 drop_err", 32'(drop_err), 32'h0);

        // N=3: grant pointer wraps 2 -> 0
        d_valid3 = 1'b0;
        out_ready3 = 3'h7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst3 = 1'b0;
            #1;
            chk($sformatf("n3 in_ready %0d", i), 32'(in_ready3), 32'(3'b001 << (i % 3)));
            if (i > 0) begin
                chk($sformatf("n3 y_sel %0d", i), 32'(y_sel3), 32'((i - 1) % 3));
                chk($sformatf("n3 y_data %0d", i), 32'(y_data3), 32'(8'hA0 + 8'((i - 1) % 3)));
            end
        end

        // Out-of-range select is swallowed and flagged
        @(negedge clk);
        in_valid3 = 3'h0;
        d_valid3 = 1'b1;
        d_sel3 = 2'd3;
        d_data3 = 8'h55;
        out_ready3 = 3'h0;
        #1;
        chk("n3 oob d_ready", 32'(d_ready3), 32'h1);
        chk("n3 oob drop_err pre", 32'(drop_err3), 32'h0);
        @(negedge clk);
        d_valid3 = 1'b0;
        #1;
        chk("n3 oob drop_err", 32'(drop_err3), 32'h1);
        chk("n3 oob out_valid", 32'(out_valid3), 32'h0);
        @(negedge clk);
        d_valid3 = 1'b1;
        d_sel3 = 2'd2;
        d_data3 = 8'h66;
        #1;
        chk("n3 ch2 d_ready", 32'(d_ready3), 32'h1);
        @(negedge clk);
        d_valid3 = 1'b0;
        #1;
        chk("n3 ch2 out_valid", 32'(out_valid3), 32'h4);
        chk("n3 ch2 out_data", 32'(out_data3[23:16]), 32'h66);
        chk("n3 drop_err sticky", 32'(drop_err3), 32'h1);
        @(negedge clk);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        #1;
        chk("n3 drop_err cleared", 32'(drop_err3), 32'h0);
        chk("n3 out_valid cleared", 32'(out_valid3), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
